// File: rtl/reset_pkg.sv
// Shared state encoding and parameter defaults for the reset sequencer.
package reset_pkg;
  typedef enum logic [1:0] {
    ASSERT = 2'd0,
    WAIT   = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int LN_DEF = 5;
  localparam int NR_DEF = 3;
  localparam int TW_DEF = 4;
endpackage

// File: rtl/reset_cnt.sv
// Up-counter with synchronous clear and enable; tc flags the all-ones value.
module reset_cnt #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + 1'b1;
  end

  assign tc = &q;
endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: holds all domains in reset for 2**LN cycles, then releases
// them one at a time in index order, each gated by its ready or a timeout.
module reset_seq
  import reset_pkg::*;
#(
  parameter int LN = LN_DEF,
  parameter int NR = NR_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  input  logic [NR-1:0] rdy_i,
  output logic [NR-1:0] rst_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);
  localparam int KW = (NR > 1) ? $clog2(NR) : 1;

  state_t        state, state_nx;
  logic [KW-1:0] k, k_nx;
  logic [NR-1:0] rst_nx;
  logic          done_nx, err_nx;
  logic          cnt_clr, cnt_en, cnt_tc;
  logic          tmr_clr, tmr_en, tmr_tc;
  logic          go;

  reset_cnt #(.W(LN)) u_cnt (
    .clk (clk_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  reset_cnt #(.W(TW)) u_tmr (
    .clk (clk_i),
    .rst (rst_i),
    .clr (tmr_clr),
    .en  (tmr_en),
    .tc  (tmr_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ASSERT;
      k      <= '0;
      rst_o  <= '1;
      done_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      state  <= state_nx;
      k      <= k_nx;
      rst_o  <= rst_nx;
      done_o <= done_nx;
      err_o  <= err_nx;
    end
  end

  // Timer is cleared unless it is actively counting a WAIT stage, so every
  // stage (and every re-entry into WAIT) starts its timeout from zero.
  always_comb begin
    state_nx = state;
    k_nx     = k;
    rst_nx   = rst_o;
    done_nx  = done_o;
    err_nx   = err_o;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    tmr_clr  = 1'b1;
    tmr_en   = 1'b0;
    go       = 1'b0;
    if (req_i) begin
      state_nx = ASSERT;
      rst_nx   = '1;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      cnt_clr  = 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          rst_nx = '1;
          cnt_en = 1'b1;
          if (cnt_tc) begin
            rst_nx[0] = 1'b0;
            k_nx      = '0;
            state_nx  = WAIT;
          end
        end
        WAIT: begin
          go = rdy_i[k] | tmr_tc;
          if (!rdy_i[k] && tmr_tc) err_nx = 1'b1;
          if (go) begin
            if (k == KW'(NR - 1)) begin
              state_nx = DONE;
              done_nx  = 1'b1;
            end else begin
              k_nx = k + 1'b1;
              for (int i = 1; i < NR; i++)
                if (k == KW'(i - 1)) rst_nx[i] = 1'b0;
            end
          end else begin
            tmr_clr = 1'b0;
            tmr_en  = 1'b1;
          end
        end
        DONE: ;
        default: state_nx = ASSERT;
      endcase
    end
  end

  assign busy_o = (state != DONE);
endmodule

// File: tb/tb_reset_seq.sv
// Directed bench for reset_seq with LN=5, NR=3, TW=4 and a 10 ns clock.
module tb_reset_seq;
  logic       clk, rst, req;
  logic [2:0] rdy;
  logic [2:0] rst_o;
  logic       busy, done, err;
  int         n_chk = 0;
  int         n_fail = 0;

  reset_seq dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .req_i  (req),
    .rdy_i  (rdy),
    .rst_o  (rst_o),
    .busy_o (busy),
    .done_o (done),
    .err_o  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic [2:0] rdy;
    logic [2:0] rst;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl [8];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_rst, input logic e_busy,
                         input logic e_done, input logic e_err);
    chk({tag, " rst_o"},  {5'd0, rst_o}, {5'd0, e_rst});
    chk({tag, " busy_o"}, {7'd0, busy},  {7'd0, e_busy});
    chk({tag, " done_o"}, {7'd0, done},  {7'd0, e_done});
    chk({tag, " err_o"},  {7'd0, err},   {7'd0, e_err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end before 100000 ns");
    $fatal(1);
  end

  initial begin
    // Power-up: rdy bits driven so the releases land on edges 32, 34, 36, done on 37.
    tbl[0] = '{31, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1,  3'b000, 3'b110, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1,  3'b001, 3'b110, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1,  3'b001, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1,  3'b011, 3'b100, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1,  3'b111, 3'b000, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1,  3'b111, 3'b000, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{5,  3'b111, 3'b000, 1'b0, 1'b1, 1'b0};

    rst = 1'b0; req = 1'b0; rdy = 3'b000;
    #1 rst = 1'b1;
    #1 chk_all("reset", 3'b111, 1'b1, 1'b0, 1'b0);
    #21 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].n);
      chk_all($sformatf("pwrup[%0d]", i), tbl[i].rst, tbl[i].busy, tbl[i].done, tbl[i].err);
      rdy = tbl[i].rdy;
    end

    // Restart from DONE, then a full timeout run with rdy held low.
    req = 1'b1;
    step(1);  chk_all("restart", 3'b111, 1'b1, 1'b0, 1'b0);
    req = 1'b0; rdy = 3'b000;
    step(31); chk_all("restart e31", 3'b111, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("restart e32", 3'b110, 1'b1, 1'b0, 1'b0);
    step(15); chk_all("tmo pre", 3'b110, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("tmo d0", 3'b100, 1'b1, 1'b0, 1'b1);
    step(16); chk_all("tmo d1", 3'b000, 1'b1, 1'b0, 1'b1);
    step(16); chk_all("tmo done", 3'b000, 1'b0, 1'b1, 1'b1);

    // Held request keeps cnt at 0; early ready on later domains must not skip stage 0.
    req = 1'b1;
    step(3);  chk_all("req held", 3'b111, 1'b1, 1'b0, 1'b0);
    req = 1'b0; rdy = 3'b110;
    step(31); chk_all("early e31", 3'b111, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("early e32", 3'b110, 1'b1, 1'b0, 1'b0);
    step(15); chk_all("early hold", 3'b110, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("early tmo", 3'b100, 1'b1, 1'b0, 1'b1);
    step(1);  chk_all("early d1", 3'b000, 1'b1, 1'b0, 1'b1);
    step(1);  chk_all("early done", 3'b000, 1'b0, 1'b1, 1'b1);

    // Collision: req and rdy[0] on the same edge in WAIT.
    req = 1'b1;
    step(1);
    req = 1'b0; rdy = 3'b000;
    step(32); chk_all("coll wait", 3'b110, 1'b1, 1'b0, 1'b0);
    req = 1'b1; rdy = 3'b001;
    step(1);  chk_all("coll edge", 3'b111, 1'b1, 1'b0, 1'b0);
    req = 1'b0;
    step(31); chk_all("coll e31", 3'b111, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("coll e32", 3'b110, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("coll d0", 3'b100, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset pulse of 12 ns, mid-clock, during WAIT.
    #3 rst = 1'b1;
    #1 chk_all("async", 3'b111, 1'b1, 1'b0, 1'b0);
    #11 rst = 1'b0; rdy = 3'b000;
    step(31); chk_all("async e31", 3'b111, 1'b1, 1'b0, 1'b0);
    step(1);  chk_all("async e32", 3'b110, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 SHALL have parameter LN, default 5, meaning the initial assert phase lasts 2**LN clock cycles.
REQ-002 SHALL have parameter NR, default 3, meaning the number of sequenced reset domains (1..8).
REQ-003 SHALL have parameter TW, default 4, meaning the per-domain ready timeout is 2**TW cycles.
REQ-004 SHALL have port clk_i  input  1  meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i  input  1  meaning the asynchronous, active-high reset.
REQ-006 SHALL have port req_i  input  1  meaning a synchronous reset request; the pulse is 1 or more cycles long.
REQ-007 SHALL have port rdy_i  input  NR  meaning bit k high once domain k has finished its local init.
REQ-008 SHALL have port rst_o  output  NR  meaning the active-high reset to domain k; registered.
REQ-009 SHALL have port busy_o  output  1  meaning the sequence is in progress (state not DONE).
REQ-010 SHALL have port done_o  output  1  meaning all domains are released.
REQ-011 SHALL have port err_o  output  1  meaning a sticky flag set when at least one domain timed out.

Function
REQ-012 SHALL implement the FSM states ASSERT, WAIT and DONE, plus the registers cnt (LN bits), tmr (TW bits) and k (stage index).
REQ-013 SHALL, in ASSERT, hold all rst_o bits high and increment cnt each cycle.
REQ-014 SHALL leave ASSERT on the edge where cnt==2**LN-1. On that edge: rst_o[0]<=0, k<=0, tmr<=0, and the next state is WAIT.
REQ-015 SHALL, in WAIT with rdy_i[k]==1 and k<NR-1, do rst_o[k+1]<=0, k<=k+1 and tmr<=0.
REQ-016 SHALL, in WAIT with rdy_i[k]==1 and k==NR-1, go to DONE and set done_o<=1 on the same edge.
REQ-017 SHALL, in WAIT with rdy_i[k]==0 and tmr==2**TW-1, set err_o<=1 and advance exactly as if rdy_i[k] were 1.
REQ-018 SHALL otherwise increment tmr in WAIT. tmr wraps only through the timeout rule, never silently.
REQ-019 SHALL ignore rdy_i bits other than rdy_i[k]. Ready asserted early for a later domain does not skip any stage.
REQ-020 SHALL treat req_i==1 in any state as an immediate restart. On that edge: rst_o<=all ones, cnt<=0, done_o<=0, err_o<=0, and the next state is ASSERT.
REQ-021 SHALL give req_i priority over rdy_i and over timeout on the same edge.
REQ-022 SHALL, while req_i is held high, stay in ASSERT with cnt held at 0. Counting starts on the first edge with req_i low.
REQ-023 SHALL release rst_o bits strictly in ascending index order, one per stage. A released bit is never re-asserted except by req_i or rst_i.
REQ-024 SHALL drive busy_o as a combinational decode: busy_o = (state != DONE).

Reset
REQ-025 SHALL, while rst_i is high, asynchronously force state=ASSERT, cnt=0, tmr=0, k=0, rst_o=all ones, done_o=0 and err_o=0.
REQ-026 SHALL start counting on the first rising edge after rst_i falls. Release of rst_i need not be synchronized inside the block; the upstream reset synchronizer provides it.
REQ-027 SHALL behave identically for rst_i assertion mid-sequence, including in DONE: all domains re-enter reset immediately, without waiting for a clock edge.

Structure
REQ-028 SHALL place the state encoding (ASSERT=2'd0, WAIT=2'd1, DONE=2'd2) and the defaults for LN, NR and TW in a shared package, reset_pkg.
REQ-029 SHALL use one sub-module, reset_cnt: a width-parameterised up-counter with clear, enable and terminal-count output, instantiated twice (for cnt and tmr).
REQ-030 SHALL contain no latches or combinational paths from inputs to rst_o.

Verification (LN=5, NR=3, TW=4, 10 ns clock)
REQ-031 SHALL cover power-up: rst_i is released and rdy_i tracks each domain one cycle after its release.
- Required response: rst_o[0] falls on edge 32.
- rst_o[1] falls on edge 34 and rst_o[2] on edge 36.
- done_o rises on edge 37; err_o stays 0.
REQ-032 SHALL cover timeout: rdy_i held at 0.
- Required response: rst_o[1] falls on edge 32+16.
- err_o rises on that same edge.
- done_o rises on edge 32+48; err_o remains 1.
REQ-033 SHALL cover a restart from DONE: req_i pulsed for 1 cycle.
- Required response: rst_o=3'b111 and done_o=0 on the next edge.
- The sequence repeats, with rst_o[0] falling 32 edges after req_i falls.
REQ-034 SHALL cover a collision: req_i and rdy_i[k] both asserted on the same edge while in WAIT.
- Required response: ASSERT is entered and k does not advance.
REQ-035 SHALL cover an asynchronous reset: rst_i pulsed for 12 ns, mid-clock, during WAIT.
- Required response: rst_o goes to all ones before the next rising edge.
- After release, the full 32-cycle assert phase is observed again.
